// File: rtl/pwm_deadtime.sv
// Complementary high/low gate-drive generator with programmable rising/falling dead-bands,
// per-output polarity and a synchronized external fault shutdown, configured over APB.
module pwm_deadtime #(
    parameter int CNT_W = 8
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             PENABLE,
    input  logic             PSELDT,
    input  logic [3:2]       PADDR,
    input  logic             PWRITE,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    input  logic             PWM_IN,
    input  logic             FAULTn,
    output logic             PWM_H,
    output logic             PWM_L,
    output logic             INTdt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEAD_R = 3'd1,
        H_ON   = 3'd2,
        DEAD_F = 3'd3,
        L_ON   = 3'd4
    } state_t;

    logic             en_q, invh_q, invl_q, ie_q, fault_sts_q;
    logic             en_d, invh_d, invl_d, ie_d, fault_sts_d;
    logic [CNT_W-1:0] rise_q, rise_d, fall_q, fall_d, cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    state_t           state_q, state_d;
    logic             pwm_h_q, pwm_l_q;
    logic             wr, rd, enter, enter_up;
    logic [7:0]       cnt8;
    logic             unused_pwdata;

    assign wr = PSELDT & PWRITE & PENABLE;
    assign rd = PSELDT & ~PWRITE & PENABLE;
    assign unused_pwdata = ^PWDATA;

    generate
        if (CNT_W >= 8) begin : g_cnt_trunc
            assign cnt8 = cnt_q[7:0];
        end else begin : g_cnt_ext
            assign cnt8 = {{(8 - CNT_W){1'b0}}, cnt_q};
        end
    endgenerate

    always_comb begin
        en_d   = en_q;
        invh_d = invh_q;
        invl_d = invl_q;
        ie_d   = ie_q;
        rise_d = rise_q;
        fall_d = fall_q;
        if (wr && PADDR == 2'd0) begin
            en_d   = PWDATA[0];
            invh_d = PWDATA[1];
            invl_d = PWDATA[2];
            ie_d   = PWDATA[3];
        end
        if (wr && PADDR == 2'd1) rise_d = PWDATA[CNT_W-1:0];
        if (wr && PADDR == 2'd2) fall_d = PWDATA[CNT_W-1:0];
        // A fault seen this cycle wins over a simultaneous write-1-to-clear.
        if (!sync2_q)
            fault_sts_d = 1'b1;
        else if (wr && PADDR == 2'd0 && PWDATA[4])
            fault_sts_d = 1'b0;
        else
            fault_sts_d = fault_sts_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enter    = 1'b0;
        enter_up = PWM_IN;
        if (!en_q || !sync2_q || fault_sts_q) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE:   enter = 1'b1;
                L_ON:   enter = PWM_IN;
                H_ON:   enter = ~PWM_IN;
                DEAD_R: begin
                    if (!PWM_IN) begin
                        state_d = L_ON;
                        cnt_d   = '0;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_d = H_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DEAD_F: begin
                    if (PWM_IN) begin
                        state_d = H_ON;
                        cnt_d   = '0;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_d = L_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            // A zero dead-band skips the dead state entirely.
            if (enter) begin
                if (enter_up) begin
                    state_d = (rise_q == '0) ? H_ON : DEAD_R;
                    cnt_d   = rise_q;
                end else begin
                    state_d = (fall_q == '0) ? L_ON : DEAD_F;
                    cnt_d   = fall_q;
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en_q        <= 1'b0;
            invh_q      <= 1'b0;
            invl_q      <= 1'b0;
            ie_q        <= 1'b0;
            fault_sts_q <= 1'b0;
            rise_q      <= '0;
            fall_q      <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            pwm_h_q     <= 1'b0;
            pwm_l_q     <= 1'b0;
        end else begin
            en_q        <= en_d;
            invh_q      <= invh_d;
            invl_q      <= invl_d;
            ie_q        <= ie_d;
            fault_sts_q <= fault_sts_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            sync1_q     <= FAULTn;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pwm_h_q     <= (state_d == H_ON) ^ invh_d;
            pwm_l_q     <= (state_d == L_ON) ^ invl_d;
        end
    end

    always_comb begin
        PRDATA = 32'd0;
        if (rd) begin
            unique case (PADDR)
                2'd0:    PRDATA = {27'd0, fault_sts_q, ie_q, invl_q, invh_q, en_q};
                2'd1:    PRDATA = 32'(rise_q);
                2'd2:    PRDATA = 32'(fall_q);
                default: PRDATA = {16'd0, cnt8, 5'd0, state_q};
            endcase
        end
    end

    assign PWM_H = pwm_h_q;
    assign PWM_L = pwm_l_q;
    assign INTdt = fault_sts_q & ie_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Randomized and directed bench for pwm_deadtime against a behavioural model of the
// dead-band rules, fault synchronizer and register map.
module tb_pwm_deadtime;
    logic        PCLK = 1'b0;
    logic        PRESETn, PENABLE, PSELDT, PWRITE, PWM_IN, FAULTn;
    logic [1:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PWM_H, PWM_L, INTdt;

    int n_vec = 0;
    int n_err = 0;

    // model: mode 0 idle, 1 dead toward high, 2 high on, 3 dead toward low, 4 low on
    logic [4:0] m_con;
    int         m_rise, m_fall, m_mode, m_remain;
    bit         m_s1, m_s2;

    always #5 PCLK = ~PCLK;

    pwm_deadtime #(.CNT_W(8)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PENABLE(PENABLE), .PSELDT(PSELDT),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PWM_IN(PWM_IN), .FAULTn(FAULTn), .PWM_H(PWM_H), .PWM_L(PWM_L), .INTdt(INTdt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_con = '0; m_rise = 0; m_fall = 0; m_mode = 0; m_remain = 0;
        m_s1 = 1'b1; m_s2 = 1'b1;
    endtask

    task automatic model_edge();
        bit         wr, abort, enter;
        logic [4:0] ncon;
        int         d;
        wr    = PSELDT && PWRITE && PENABLE;
        abort = !m_con[0] || !m_s2 || m_con[4];
        enter = 1'b0;
        ncon  = m_con;
        if (abort) begin
            m_mode = 0; m_remain = 0;
        end else begin
            case (m_mode)
                0: enter = 1'b1;
                2: enter = !PWM_IN;
                4: enter = PWM_IN;
                1: if (!PWM_IN) begin m_mode = 4; m_remain = 0; end
                   else begin m_remain--; if (m_remain == 0) m_mode = 2; end
                3: if (PWM_IN) begin m_mode = 2; m_remain = 0; end
                   else begin m_remain--; if (m_remain == 0) m_mode = 4; end
                default: m_mode = 0;
            endcase
            if (enter) begin
                d = PWM_IN ? m_rise : m_fall;
                if (d == 0) begin m_mode = PWM_IN ? 2 : 4; m_remain = 0; end
                else begin m_mode = PWM_IN ? 1 : 3; m_remain = d; end
            end
        end
        if (wr && PADDR == 2'd0) ncon[3:0] = PWDATA[3:0];
        ncon[4] = !m_s2 ? 1'b1 : (wr && PADDR == 2'd0 && PWDATA[4]) ? 1'b0 : m_con[4];
        if (wr && PADDR == 2'd1) m_rise = int'(PWDATA[7:0]);
        if (wr && PADDR == 2'd2) m_fall = int'(PWDATA[7:0]);
        m_con = ncon;
        m_s2  = m_s1;
        m_s1  = FAULTn;
    endtask

    function automatic logic [31:0] exp_rd();
        int c;
        if (!(PSELDT && !PWRITE && PENABLE)) return 32'd0;
        c = (m_mode == 1 || m_mode == 3) ? m_remain : 0;
        case (PADDR)
            2'd0:    return {27'd0, m_con};
            2'd1:    return 32'(m_rise);
            2'd2:    return 32'(m_fall);
            default: return {16'd0, 8'(c), 5'd0, 3'(m_mode)};
        endcase
    endfunction

    // Check everything observable in the low phase, then advance one clock.
    task automatic tick();
        logic exp_h, exp_l;
        #1;
        exp_h = (m_mode == 2) ^ m_con[1];
        exp_l = (m_mode == 4) ^ m_con[2];
        chk("PRDATA", PRDATA, exp_rd());
        chk("PWM_H", PWM_H, exp_h);
        chk("PWM_L", PWM_L, exp_l);
        chk("INTdt", INTdt, m_con[4] & m_con[3]);
        chk("overlap", (PWM_H ^ m_con[1]) & (PWM_L ^ m_con[2]), 1'b0);
        @(posedge PCLK);
        model_edge();
        @(negedge PCLK);
    endtask

    task automatic bus_idle();
        PSELDT = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
        PSELDT = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick();
        bus_idle();
    endtask

    task automatic apb_read_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        PSELDT = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
        #1 chk(tag, PRDATA, exp);
        tick();
        bus_idle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset();
        #2 PRESETn = 1'b0;
        #1 chk("arst_H", PWM_H, 1'b0);
        chk("arst_L", PWM_L, 1'b0);
        model_reset();
        @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        int          r;
        PRESETn = 1'b0; PWM_IN = 1'b0; FAULTn = 1'b1; PADDR = 2'd0; PWDATA = '0;
        bus_idle();
        model_reset();
        @(negedge PCLK); @(negedge PCLK);
        #1 chk("rst_H", PWM_H, 1'b0);
        chk("rst_L", PWM_L, 1'b0);
        PRESETn = 1'b1;
        @(negedge PCLK);

        // basic dead-band timing
        apb_write(2'd1, 32'd3);
        apb_write(2'd2, 32'd2);
        apb_write(2'd0, 32'h01);
        run(5);
        chk("t1_L_idle", PWM_L, 1'b1);
        PWM_IN = 1'b1;
        tick();
        chk("t1_L_off_k", PWM_L, 1'b0);
        tick(); tick();
        chk("t1_H_k2", PWM_H, 1'b0);
        tick();
        chk("t1_H_k3", PWM_H, 1'b1);
        PWM_IN = 1'b0;
        tick();
        chk("t1_H_off_m", PWM_H, 1'b0);
        tick();
        chk("t1_L_m1", PWM_L, 1'b0);
        tick();
        chk("t1_L_m2", PWM_L, 1'b1);

        // swallowed short pulse
        apb_write(2'd1, 32'd5);
        PWM_IN = 1'b1;
        tick();
        PSELDT = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 2'd3;
        #1 chk("sw_state_dr", PRDATA[2:0], 3'd1);
        chk("sw_count", PRDATA[15:8], 8'd5);
        tick();
        PWM_IN = 1'b0;
        tick();
        chk("sw_L", PWM_L, 1'b1);
        chk("sw_H", PWM_H, 1'b0);
        chk("sw_state_lon", PRDATA[2:0], 3'd4);
        bus_idle();

        // zero dead-band
        apb_write(2'd1, 32'd0);
        apb_write(2'd2, 32'd0);
        PWM_IN = 1'b1;
        tick();
        chk("z_rise_H", PWM_H, 1'b1);
        chk("z_rise_L", PWM_L, 1'b0);
        PWM_IN = 1'b0;
        tick();
        chk("z_fall_H", PWM_H, 1'b0);
        chk("z_fall_L", PWM_L, 1'b1);

        // fault shutdown and recovery
        apb_write(2'd1, 32'd1);
        apb_write(2'd0, 32'h09);
        PWM_IN = 1'b1;
        run(3);
        chk("f_pre_H", PWM_H, 1'b1);
        FAULTn = 1'b0;
        tick();
        FAULTn = 1'b1;
        tick();
        chk("f_j1_H", PWM_H, 1'b1);
        tick();
        chk("f_j2_H", PWM_H, 1'b0);
        chk("f_j2_L", PWM_L, 1'b0);
        chk("f_int", INTdt, 1'b1);
        run(4);
        chk("f_hold_H", PWM_H, 1'b0);
        apb_write(2'd0, 32'h19);
        chk("f_int_clr", INTdt, 1'b0);
        run(3);
        chk("f_resume_H", PWM_H, 1'b1);

        // polarity with disable, and unselected read
        apb_write(2'd0, 32'h06);
        run(2);
        chk("inv_H", PWM_H, 1'b1);
        chk("inv_L", PWM_L, 1'b1);
        apb_read_chk("inv_rd_con", 2'd0, 32'h6);
        PSELDT = 1'b0; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 2'd0;
        #1 chk("unsel_rd", PRDATA, 32'd0);
        tick();
        bus_idle();

        // asynchronous reset during a long rising dead-band
        apb_write(2'd1, 32'd200);
        apb_write(2'd0, 32'h03);
        PWM_IN = 1'b0;
        run(4);
        PWM_IN = 1'b1;
        tick();
        chk("ar_pre_H", PWM_H, 1'b1);
        async_reset();
        for (int a = 0; a < 4; a++) apb_read_chk("ar_reg_zero", 2'(a), 32'd0);

        // randomized traffic
        apb_write(2'd2, 32'd2);
        apb_write(2'd0, 32'h01);
        for (int i = 0; i < 1500; i++) begin
            FAULTn = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 3) == 0) PWM_IN = ~PWM_IN;
            r = $urandom_range(0, 19);
            d = $urandom;
            PADDR = 2'($urandom_range(0, 3));
            if (r < 3) begin
                PSELDT = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1;
                if (r == 0) begin
                    PADDR = 2'd0;
                    d[0] = ($urandom_range(0, 7) != 0);
                end else begin
                    PADDR = 2'(r);
                    d[7:0] = 8'($urandom_range(0, 6));
                end
                PWDATA = d;
            end else if (r < 8) begin
                PSELDT = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0;
            end else if (r < 11) begin
                PSELDT = $urandom_range(0, 1) == 1; PENABLE = ~PSELDT;
                PWRITE = 1'b1; PWDATA = d;
            end else begin
                bus_idle();
            end
            if ($urandom_range(0, 399) == 0) async_reset();
            tick();
            bus_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pwm_deadtime.md
Name: pwm_deadtime

Overview:
- Complementary-output dead-time generator that sits directly downstream of one PTC channel and consumes its PWM_OUT as PWM_IN.
- Produces a high-side/low-side gate-drive pair with programmable rising and falling dead-bands, per-output polarity, and an external fault shutdown.
- Configured over the same APB bus, with PADDR[3:2] register decode and the same read/write qualification as the PTC channels.
- One instance per PWM channel.

Parameters:
CNT_W, 8, width of the dead-time counters and of the DT_RISE/DT_FALL registers (1..16).

Ports:
PCLK  in  1  clock.
PRESETn  in  1  reset; asynchronous, active-low.
PENABLE  in  1  APB enable.
PSELDT  in  1  APB select for this instance.
PADDR  in  2  [3:2] register select.
PWRITE  in  1  APB write.
PWDATA  in  32  APB write data.
PRDATA  out  32  APB read data; 0 when not reading.
PWM_IN  in  1  PWM from the PTC channel, same clock domain.
FAULTn  in  1  external fault, active-low, asynchronous to PCLK.
PWM_H  out  1  high-side drive.
PWM_L  out  1  low-side drive.
INTdt  out  1  fault interrupt.

Behaviour:
- Register qualification: write = PSELDT & PWRITE & PENABLE; read = PSELDT & ~PWRITE & PENABLE.
- 0x0 DT_CON [4:0]:
  - b0 EN
  - b1 INVH
  - b2 INVL
  - b3 IE
  - b4 FAULT_STS: sticky; write 1 clears; writing 0 has no effect.
- 0x4 DT_RISE[CNT_W-1:0]: both-off cycles before PWM_H asserts. 0x8 DT_FALL[CNT_W-1:0]: both-off cycles before PWM_L asserts. Unused bits read 0.
- 0xC DT_STAT, read-only: [2:0] state code, [15:8] current count (zero-extended or truncated to 8 bits).
- Reset: all registers 0, state IDLE, PWM_H=0, PWM_L=0, synchronizer flops 1 (no fault).
- FAULTn path: 2-flop synchronizer to fault_s.
  - fault_s=0 sets FAULT_STS on the next edge.
  - Set has priority over a same-cycle W1C.
- FSM states: IDLE=0, DEAD_R=1, H_ON=2, DEAD_F=3, L_ON=4.
  - Any state -> IDLE when EN=0, fault_s=0, or FAULT_STS=1.
  - IDLE -> DEAD_R if PWM_IN=1, else DEAD_F.
  - L_ON & PWM_IN=1 -> DEAD_R, loading DT_RISE.
  - H_ON & PWM_IN=0 -> DEAD_F, loading DT_FALL.
  - Dead state -> ON state when the loaded count expires. The dead state lasts exactly D cycles; D=0 goes directly to the ON state in one edge.
  - DEAD_R & PWM_IN=0 -> L_ON next edge: the pulse is swallowed and PWM_H never asserts.
  - DEAD_F & PWM_IN=1 -> H_ON next edge.
- Outputs are registered from the next-state decode, so they change on the same edge as the state:
  - PWM_H = (state==H_ON) ^ INVH
  - PWM_L = (state==L_ON) ^ INVL
  - In IDLE and dead states both drives are inactive, i.e. equal to the INV bits.
- Latency:
  - PWM_IN rise sampled at edge k: PWM_L goes inactive at k; PWM_H goes active at k+DT_RISE.
  - Falling edge is symmetric with DT_FALL.
  - PWM_H and PWM_L are never simultaneously active.
- Fault latency: FAULTn low before edge j gives both outputs inactive at edge j+2. The outputs stay inactive until FAULT_STS is cleared and EN=1, then re-enter via IDLE.
- Writing DT_RISE/DT_FALL while in a dead state does not alter the running count; the new value applies at the next load.
- EN write 1 -> 0: IDLE and outputs inactive at the next edge.
- INTdt = FAULT_STS & IE, combinational from registers.
- Asynchronous reset mid-operation: outputs 0 immediately, without waiting for a PCLK edge.

Test Plan:
- DT_RISE=3, DT_FALL=2, DT_CON=0x01, PWM_IN low -> PWM_L=1. PWM_IN rises at edge k -> PWM_L=0 at k, PWM_H=1 at k+3. PWM_IN falls at edge m -> PWM_H=0 at m, PWM_L=1 at m+2. No cycle has both outputs at 1.
- DT_RISE=5, PWM_IN high for 2 cycles -> PWM_H stays 0; PWM_L returns to 1 on the edge PWM_IN=0 is sampled. DT_STAT shows 1 then 4.
- DT_RISE=0, DT_FALL=0 -> PWM_L 1->0 and PWM_H 0->1 on the same edge, and the reverse on the fall.
- In H_ON, DT_CON=0x09, FAULTn low 1 cycle -> both outputs 0 by the 2nd edge, FAULT_STS=1, INTdt=1. Outputs stay 0 after FAULTn returns high. Write 0x19 -> FAULT_STS=0, INTdt=0, normal PWM resumes via IDLE.
- DT_CON=0x06 (EN=0, INVH=1, INVL=1) -> PWM_H=1, PWM_L=1 (both inactive). Read 0x0 returns 0x6; an unselected read returns 0.
- PRESETn asserted in DEAD_R with DT_RISE=200 -> PWM_H=PWM_L=0 with no PCLK edge, and all registers read 0 after release.
